// File: rtl/score_controller.sv
// rtl/score_controller.sv - Pong score keeping, serve/game-over sequencing and shared digit mux
module score_controller #(
   parameter logic [11:0] LEFT_OFFSET  = 12'd280,
   parameter logic [11:0] RIGHT_OFFSET = 12'd344,
   parameter logic [11:0] SPLIT_X      = 12'd320,
   parameter logic [2:0]  WIN_SCORE    = 3'd7,
   parameter logic [7:0]  SERVE_FRAMES = 8'd60,
   parameter logic [7:0]  FLASH_FRAMES = 8'd15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [11:0] i_x,
   input  logic        i_frame_tick,
   input  logic        i_goal_left,
   input  logic        i_goal_right,
   input  logic        i_restart,
   output logic [2:0]  o_gen_score,
   output logic [11:0] o_gen_offset,
   output logic        o_gen_blank,
   output logic        o_ball_enable,
   output logic        o_serve_dir,
   output logic        o_game_over,
   output logic        o_winner,
   output logic [2:0]  o_score_left,
   output logic [2:0]  o_score_right
);

   typedef enum logic [1:0] {
      ST_SERVE     = 2'd0,
      ST_PLAY      = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_t;

   state_t      r_state;
   logic [2:0]  r_score_left;
   logic [2:0]  r_score_right;
   logic [7:0]  r_serve_cnt;
   logic [7:0]  r_flash_cnt;
   logic        r_flash_on;
   logic        r_serve_dir;
   logic        r_winner;
   logic [2:0]  r_gen_score;
   logic [11:0] r_gen_offset;
   logic        r_gen_blank;

   state_t      w_state_next;
   logic [2:0]  w_score_left_next;
   logic [2:0]  w_score_right_next;
   logic [7:0]  w_serve_cnt_next;
   logic [7:0]  w_flash_cnt_next;
   logic        w_flash_on_next;
   logic        w_serve_dir_next;
   logic        w_winner_next;
   logic [2:0]  w_left_plus;
   logic [2:0]  w_right_plus;
   logic        w_side_right;
   logic        w_blank;

   // Saturating increments: a score can never pass WIN_SCORE, so 3-bit math cannot wrap
   always_comb begin
      w_left_plus  = r_score_left;
      w_right_plus = r_score_right;
      if (r_score_left < WIN_SCORE) begin
         w_left_plus = r_score_left + 3'd1;
      end
      if (r_score_right < WIN_SCORE) begin
         w_right_plus = r_score_right + 3'd1;
      end
   end

   // Next-state and next-datapath logic; restart overrides any goal or tick this cycle
   always_comb begin
      w_state_next       = r_state;
      w_score_left_next  = r_score_left;
      w_score_right_next = r_score_right;
      w_serve_cnt_next   = r_serve_cnt;
      w_flash_cnt_next   = r_flash_cnt;
      w_flash_on_next    = r_flash_on;
      w_serve_dir_next   = r_serve_dir;
      w_winner_next      = r_winner;

      if (i_restart) begin
         w_state_next       = ST_SERVE;
         w_score_left_next  = 3'd0;
         w_score_right_next = 3'd0;
         w_serve_cnt_next   = 8'd0;
         w_flash_cnt_next   = 8'd0;
         w_flash_on_next    = 1'b1;
      end else begin
         unique case (r_state)
            ST_SERVE: begin
               if (i_frame_tick) begin
                  if (r_serve_cnt == SERVE_FRAMES - 8'd1) begin
                     w_serve_cnt_next = 8'd0;
                     w_state_next     = ST_PLAY;
                  end else begin
                     w_serve_cnt_next = r_serve_cnt + 8'd1;
                  end
               end
            end
            ST_PLAY: begin
               // Left goal has priority when both paddles report a goal together
               if (i_goal_left) begin
                  w_score_left_next = w_left_plus;
                  w_serve_dir_next  = 1'b1;
                  w_serve_cnt_next  = 8'd0;
                  if (w_left_plus == WIN_SCORE) begin
                     w_state_next     = ST_GAME_OVER;
                     w_winner_next    = 1'b0;
                     w_flash_cnt_next = 8'd0;
                     w_flash_on_next  = 1'b1;
                  end else begin
                     w_state_next = ST_SERVE;
                  end
               end else if (i_goal_right) begin
                  w_score_right_next = w_right_plus;
                  w_serve_dir_next   = 1'b0;
                  w_serve_cnt_next   = 8'd0;
                  if (w_right_plus == WIN_SCORE) begin
                     w_state_next     = ST_GAME_OVER;
                     w_winner_next    = 1'b1;
                     w_flash_cnt_next = 8'd0;
                     w_flash_on_next  = 1'b1;
                  end else begin
                     w_state_next = ST_SERVE;
                  end
               end
            end
            ST_GAME_OVER: begin
               if (i_frame_tick) begin
                  if (r_flash_cnt == FLASH_FRAMES - 8'd1) begin
                     w_flash_cnt_next = 8'd0;
                     w_flash_on_next  = ~r_flash_on;
                  end else begin
                     w_flash_cnt_next = r_flash_cnt + 8'd1;
                  end
               end
            end
            default: begin
               w_state_next = ST_SERVE;
            end
         endcase
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_SERVE;
         r_score_left  <= 3'd0;
         r_score_right <= 3'd0;
         r_serve_cnt   <= 8'd0;
         r_flash_cnt   <= 8'd0;
         r_flash_on    <= 1'b1;
         r_serve_dir   <= 1'b0;
         r_winner      <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_score_left  <= w_score_left_next;
         r_score_right <= w_score_right_next;
         r_serve_cnt   <= w_serve_cnt_next;
         r_flash_cnt   <= w_flash_cnt_next;
         r_flash_on    <= w_flash_on_next;
         r_serve_dir   <= w_serve_dir_next;
         r_winner      <= w_winner_next;
      end
   end

   // Digit select from pixel x; blank the winner's digit during the off phase of the flash
   always_comb begin
      w_side_right = (i_x >= SPLIT_X);
      w_blank      = (r_state == ST_GAME_OVER) & ~r_flash_on & (w_side_right == r_winner);
   end

   // Registered digit mux feeding the shared score_generator
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_gen_score  <= 3'd0;
         r_gen_offset <= LEFT_OFFSET;
         r_gen_blank  <= 1'b0;
      end else begin
         r_gen_score  <= w_side_right ? r_score_right : r_score_left;
         r_gen_offset <= w_side_right ? RIGHT_OFFSET : LEFT_OFFSET;
         r_gen_blank  <= w_blank;
      end
   end

   // Output decode from the state register
   always_comb begin
      o_ball_enable = (r_state == ST_PLAY);
      o_game_over   = (r_state == ST_GAME_OVER);
      o_serve_dir   = r_serve_dir;
      o_winner      = r_winner;
      o_score_left  = r_score_left;
      o_score_right = r_score_right;
      o_gen_score   = r_gen_score;
      o_gen_offset  = r_gen_offset;
      o_gen_blank   = r_gen_blank;
   end

endmodule

// File: tb/tb_score_controller.sv
// tb/tb_score_controller.sv - self-checking bench for score_controller
module tb_score_controller;

   localparam int SERVE_N = 60;
   localparam int FLASH_N = 15;
   localparam int WIN_N   = 7;

   logic        clk;
   logic        i_rst;
   logic [11:0] i_x;
   logic        i_frame_tick;
   logic        i_goal_left;
   logic        i_goal_right;
   logic        i_restart;
   logic [2:0]  o_gen_score;
   logic [11:0] o_gen_offset;
   logic        o_gen_blank;
   logic        o_ball_enable;
   logic        o_serve_dir;
   logic        o_game_over;
   logic        o_winner;
   logic [2:0]  o_score_left;
   logic [2:0]  o_score_right;

   int n_vec;
   int n_err;

   score_controller dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_x          (i_x),
      .i_frame_tick (i_frame_tick),
      .i_goal_left  (i_goal_left),
      .i_goal_right (i_goal_right),
      .i_restart    (i_restart),
      .o_gen_score  (o_gen_score),
      .o_gen_offset (o_gen_offset),
      .o_gen_blank  (o_gen_blank),
      .o_ball_enable(o_ball_enable),
      .o_serve_dir  (o_serve_dir),
      .o_game_over  (o_game_over),
      .o_winner     (o_winner),
      .o_score_left (o_score_left),
      .o_score_right(o_score_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 = serve, 1 = play, 2 = game over
   int m_valid;
   int m_phase;
   int m_sl, m_sr;
   int m_serve_ticks;
   int m_over_ticks;
   int m_dir, m_winner;
   int e_score, e_off, e_blank;

   initial m_valid = 0;

   always @(posedge clk) begin
      if (i_rst) begin
         m_valid = 1;
         m_phase = 0; m_sl = 0; m_sr = 0;
         m_serve_ticks = 0; m_over_ticks = 0;
         m_dir = 0; m_winner = 0;
         e_score = 0; e_off = 280; e_blank = 0;
      end else if (m_valid != 0) begin
         begin
            int right_side;
            int flash_on;
            right_side = (int'(i_x) >= 320) ? 1 : 0;
            flash_on   = (((m_over_ticks / FLASH_N) % 2) == 0) ? 1 : 0;
            e_score = right_side ? m_sr : m_sl;
            e_off   = right_side ? 344 : 280;
            e_blank = (m_phase == 2 && flash_on == 0 && right_side == m_winner) ? 1 : 0;
         end
         if (i_restart) begin
            m_sl = 0; m_sr = 0; m_serve_ticks = 0; m_over_ticks = 0; m_phase = 0;
         end else if (m_phase == 0) begin
            if (i_frame_tick) begin
               m_serve_ticks++;
               if (m_serve_ticks == SERVE_N) begin
                  m_serve_ticks = 0;
                  m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            if (i_goal_left || i_goal_right) begin
               if (i_goal_left) begin
                  m_sl++; m_dir = 1;
               end else begin
                  m_sr++; m_dir = 0;
               end
               if (m_sl == WIN_N || m_sr == WIN_N) begin
                  m_phase = 2;
                  m_winner = (m_sr == WIN_N) ? 1 : 0;
                  m_over_ticks = 0;
               end else begin
                  m_phase = 0;
               end
            end
         end else begin
            if (i_frame_tick) m_over_ticks++;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid != 0) begin
         check("ball_enable", 32'(o_ball_enable), (m_phase == 1) ? 1 : 0);
         check("game_over",   32'(o_game_over),   (m_phase == 2) ? 1 : 0);
         check("serve_dir",   32'(o_serve_dir),   m_dir);
         check("score_left",  32'(o_score_left),  m_sl);
         check("score_right", 32'(o_score_right), m_sr);
         check("gen_score",   32'(o_gen_score),   e_score);
         check("gen_offset",  32'(o_gen_offset),  e_off);
         check("gen_blank",   32'(o_gen_blank),   e_blank);
         if (m_phase == 2) check("winner", 32'(o_winner), m_winner);
      end
   end

   int x_next;
   int x_stride;

   task automatic cyc(input logic tk, input logic gl, input logic gr, input logic rs);
      i_x          = 12'(x_next);
      x_next       = (x_next + x_stride) % 640;
      i_frame_tick = tk;
      i_goal_left  = gl;
      i_goal_right = gr;
      i_restart    = rs;
      @(posedge clk);
      #1;
      i_frame_tick = 1'b0;
      i_goal_left  = 1'b0;
      i_goal_right = 1'b0;
      i_restart    = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      x_next = 0; x_stride = 37;
      i_rst = 1'b0; i_x = 12'd0;
      i_frame_tick = 1'b0; i_goal_left = 1'b0; i_goal_right = 1'b0; i_restart = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      check("rst_gen_offset", 32'(o_gen_offset), 280);
      check("rst_ball", 32'(o_ball_enable), 0);

      // Goal during serve is ignored
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("serve_goal_ignored", 32'(o_score_left), 0);

      // First serve: enabled only after the 60th tick
      frames(SERVE_N - 1);
      check("serve_59_ball", 32'(o_ball_enable), 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      check("serve_60_ball", 32'(o_ball_enable), 1);

      // Left goal
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("goal_l_score", 32'(o_score_left), 1);
      check("goal_l_dir", 32'(o_serve_dir), 1);
      check("goal_l_ball", 32'(o_ball_enable), 0);
      frames(SERVE_N);
      check("reserve_ball", 32'(o_ball_enable), 1);

      // Simultaneous goals: left wins
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      check("both_left", 32'(o_score_left), 2);
      check("both_right", 32'(o_score_right), 0);

      // Right runs to 7; goals share a cycle with a frame tick
      for (int g = 0; g < WIN_N; g++) begin
         frames(SERVE_N);
         cyc(1'b1, 1'b0, 1'b1, 1'b0);
      end
      check("over_flag", 32'(o_game_over), 1);
      check("over_winner", 32'(o_winner), 1);
      check("over_score_r", 32'(o_score_right), 7);

      // Flash: off phase begins after 15 ticks
      frames(FLASH_N);
      i_x = 12'd400;
      @(posedge clk); #1;
      check("flash_off_right", 32'(o_gen_blank), 1);
      i_x = 12'd100;
      @(posedge clk); #1;
      check("flash_off_left", 32'(o_gen_blank), 0);
      frames(FLASH_N);
      i_x = 12'd400;
      @(posedge clk); #1;
      check("flash_on_right", 32'(o_gen_blank), 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b1, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Restart from game over
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      check("restart_over", 32'(o_game_over), 0);
      check("restart_score_r", 32'(o_score_right), 0);

      // Restart beats a same-cycle goal in play
      frames(SERVE_N);
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      check("restart_vs_goal", 32'(o_score_left), 0);

      // Build 3 / 5
      for (int g = 0; g < 3; g++) begin
         frames(SERVE_N);
         cyc(1'b0, 1'b1, 1'b0, 1'b0);
      end
      for (int g = 0; g < 5; g++) begin
         frames(SERVE_N);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end

      // Pixel sweep
      for (int k = 0; k < 640; k++) begin
         i_x = 12'(k);
         @(posedge clk); #1;
         if (k == 319) begin
            check("sweep_319_score", 32'(o_gen_score), 3);
            check("sweep_319_off", 32'(o_gen_offset), 280);
         end
         if (k == 320) begin
            check("sweep_320_score", 32'(o_gen_score), 5);
            check("sweep_320_off", 32'(o_gen_offset), 344);
         end
      end

      // Restart mid-serve restarts the serve count
      frames(30);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      frames(SERVE_N - 1);
      check("rs_serve_59", 32'(o_ball_enable), 0);
      frames(1);
      check("rs_serve_60", 32'(o_ball_enable), 1);

      // rst mid-play
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      frames(SERVE_N);
      i_x = 12'd500;
      i_rst = 1'b1;
      @(posedge clk); #1;
      i_rst = 1'b0;
      check("rst_play_dir", 32'(o_serve_dir), 0);
      check("rst_play_score", 32'(o_score_left), 0);
      check("rst_play_off", 32'(o_gen_offset), 280);
      check("rst_play_ball", 32'(o_ball_enable), 0);
      frames(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
